reg_cfg_arbiter: RTL and testbench

- Shares one bank of DEPTH configuration registers (DATA_W bits each) between N_REQ requesters, e.g. host CSR path, strategy engines and a replay loader.
- Arbitrates requests round-robin and serves one read or write per cycle.
- Supports a grant lock so an owner can perform atomic read-modify-write sequences.
- The full bank is exported in parallel to drive the datapath's configuration inputs.

---
 rtl/reg_cfg_pkg.sv | 25 ++
 rtl/reg_cfg_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/reg_cfg_arbiter.sv | 147 ++++++++++++++
 tb/tb_reg_cfg_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_cfg_pkg.sv
// Shared types, defaults and width helpers for the configuration register arbiter.
package reg_cfg_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEF_DEPTH        = 8;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LOCK_TIMEOUT = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) r = r + 32'sd1;
    return r;
  endfunction

  // Requester index width never collapses to zero bits.
  function automatic int id_w(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

endpackage

// File: rtl/reg_cfg_arbiter_if.sv
// Requester-side bus of the configuration register arbiter: requests, grants, responses, bank export.
interface reg_cfg_arbiter_if import reg_cfg_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 3,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic                    lock_timeout;
  logic [DEPTH*DATA_W-1:0] bank_q;

  modport master (
    output req_valid, req_wr, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, lock_timeout, bank_q
  );

  modport slave (
    input  req_valid, req_wr, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, lock_timeout, bank_q
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after i_ptr wins; optional mask to a single index.
module rr_arbiter import reg_cfg_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_mask_en,
  input  logic [IW-1:0] i_mask_idx,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [N-1:0] w_req;

  // While masked only the selected requester can compete.
  always_comb begin
    if (i_mask_en) begin
      w_req = i_req & ({{(N-1){1'b0}}, 1'b1} << i_mask_idx);
    end else begin
      w_req = i_req;
    end
  end

  // Scan from the pointer, wrapping modulo N; the first hit takes the grant.
  always_comb begin : scan
    logic [IW:0]   v_sum;
    logic [IW-1:0] v_k;
    logic          v_hit;
    logic          v_found;
    o_grant = '0;
    o_idx   = '0;
    v_sum   = '0;
    v_k     = '0;
    v_hit   = 1'b0;
    v_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      v_sum   = {1'b0, i_ptr} + (IW+1)'(i);
      v_k     = (v_sum >= (IW+1)'(N)) ? IW'(v_sum - (IW+1)'(N)) : IW'(v_sum);
      v_hit   = !v_found && w_req[v_k];
      o_grant[v_k] = o_grant[v_k] | v_hit;
      o_idx   = v_hit ? v_k : o_idx;
      v_found = v_found | v_hit;
    end
  end

endmodule

// File: rtl/reg_cfg_arbiter.sv
// Shared configuration register bank: round-robin access, owner lock with idle timeout,
// one-cycle read/error responses and a parallel export of every register.
module reg_cfg_arbiter import reg_cfg_pkg::*; #(
  parameter int                N_REQ        = 4,
  parameter int                DEPTH        = DEF_DEPTH,
  parameter int                ADDR_W       = 3,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter logic [DATA_W-1:0] REG_INITIAL  = '0,
  parameter int                LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input logic              clk,
  input logic              rst,
  reg_cfg_arbiter_if.slave bus
);
  localparam int ID_W  = id_w(N_REQ);
  localparam int TMR_W = clog2(LOCK_TIMEOUT);

  state_e            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_lock_timeout;
  logic [DATA_W-1:0] r_bank [DEPTH];

  logic [N_REQ-1:0]  w_req;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_gidx;
  logic              w_xfer;
  logic              w_wr;
  logic              w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_in_range;

  assign w_req = rst ? '0 : bus.req_valid;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .i_req      (w_req),
    .i_ptr      (r_rr_ptr),
    .i_mask_en  (r_state == LOCKED),
    .i_mask_idx (r_owner),
    .o_grant    (w_grant),
    .o_idx      (w_gidx)
  );

  assign w_xfer     = |w_grant;
  assign w_in_range = (32'(w_addr) < 32'(DEPTH));

  // One-hot grant selects the winning requester's payload.
  always_comb begin
    w_wr    = 1'b0;
    w_lock  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_wr    = w_wr   | (bus.req_wr[i]   & w_grant[i]);
      w_lock  = w_lock | (bus.req_lock[i] & w_grant[i]);
      w_addr  = w_addr  | ({ADDR_W{w_grant[i]}} & bus.req_addr[i*ADDR_W +: ADDR_W]);
      w_wdata = w_wdata | ({DATA_W{w_grant[i]}} & bus.req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  // Read mux; an out-of-range address matches no entry and yields zero.
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_rdata = w_rdata | ({DATA_W{32'(w_addr) == 32'(k)}} & r_bank[k]);
    end
  end

  // Register bank storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_bank[k] <= REG_INITIAL;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_xfer && w_wr && w_in_range && (32'(w_addr) == 32'(k))) r_bank[k] <= w_wdata;
      end
    end
  end

  // Lock FSM, round-robin pointer and response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_timer        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_rdata    <= '0;
      r_rsp_err      <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_rsp_valid    <= 1'b0;
      r_lock_timeout <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr <= (32'(w_gidx) == 32'(N_REQ-1)) ? '0 : w_gidx + ID_W'(1'b1);
        if (!w_wr || !w_in_range) begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= w_gidx;
          r_rsp_rdata <= w_in_range ? w_rdata : '0;
          r_rsp_err   <= !w_in_range;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_xfer && w_lock) begin
            r_state <= LOCKED;
            r_owner <= w_gidx;
            r_timer <= '0;
          end
        end
        LOCKED: begin
          // Only the owner can be granted here, so any transfer is an owner transfer.
          if (w_xfer) begin
            if (w_lock) r_timer <= '0;
            else        r_state <= IDLE;
          end else if (r_timer == TMR_W'(LOCK_TIMEOUT-1)) begin
            r_state        <= IDLE;
            r_lock_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1'b1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_id       = r_rsp_id;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.lock_timeout = r_lock_timeout;

  for (genvar k = 0; k < DEPTH; k++) begin : g_bank_q
    assign bus.bank_q[k*DATA_W +: DATA_W] = r_bank[k];
  end

endmodule

// File: tb/tb_reg_cfg_arbiter.sv
// Scoreboard bench for reg_cfg_arbiter: directed scenarios then randomized traffic against a reference model.
module tb_reg_cfg_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int LT    = 4;
  localparam logic [DW-1:0] INIT = 32'h0000_00A5;

  typedef struct {
    int          due;
    int          id;
    logic [DW-1:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  logic [N-1:0]  p_valid, p_wr, p_lock;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];

  logic [DW-1:0] m_bank [DEPTH];
  int   m_ptr, m_owner, m_idle;
  logic m_locked;
  rsp_t rq[$];
  int   pq[$];

  reg_cfg_arbiter_if #(.N_REQ(N), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_cfg_arbiter #(
    .N_REQ(N), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW),
    .REG_INITIAL(INIT), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_bank[k] = INIT;
    m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 1'b0;
  endtask

  // Owner only while locked, otherwise first valid requester from the pointer onward.
  function automatic int exp_grant();
    if (m_locked) return p_valid[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (p_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input int g, input logic r);
    rsp_t e;
    int   a;
    if (r) begin
      model_reset();
      return;
    end
    if (g >= 0) begin
      a = int'(p_addr[g]);
      e.due = cyc + 1; e.id = g;
      if (a >= DEPTH) begin
        e.data = '0; e.err = 1'b1; rq.push_back(e);
      end else if (p_wr[g]) begin
        m_bank[a] = p_wdata[g];
      end else begin
        e.data = m_bank[a]; e.err = 1'b0; rq.push_back(e);
      end
      m_ptr = (g + 1) % N;
    end
    if (m_locked) begin
      if (g >= 0) begin
        if (p_lock[g]) m_idle = 0;
        else m_locked = 1'b0;
      end else if (m_idle == LT - 1) begin
        m_locked = 1'b0;
        pq.push_back(cyc + 1);
      end else begin
        m_idle++;
      end
    end else if (g >= 0 && p_lock[g]) begin
      m_locked = 1'b1; m_owner = g; m_idle = 0;
    end
    if (g >= 0) p_valid[g] = 1'b0;
  endtask

  task automatic cycle(input logic r);
    logic [N-1:0] e;
    int g;
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("bank_q[%0d]", k), 64'(bus.bank_q[k*DW +: DW]), 64'(m_bank[k]));
    rst = r;
    bus.req_valid = p_valid;
    bus.req_wr    = p_wr;
    bus.req_lock  = p_lock;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = p_addr[i];
      bus.req_wdata[i*DW +: DW] = p_wdata[i];
    end
    #1;
    g = r ? -1 : exp_grant();
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(e));
    model_step(g, r);
  endtask

  task automatic set_req(input int i, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1; p_wr[i] = wr; p_lock[i] = lk; p_addr[i] = a; p_wdata[i] = d;
  endtask

  // Monitor: compares every registered output against the queued predictions.
  initial begin
    rsp_t e;
    logic ev, ep;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      if (ev) begin
        e = rq.pop_front();
        if (bus.rsp_valid === 1'b1) begin
          chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
      ep = (pq.size() > 0) && (pq[0] == cyc);
      chk("lock_timeout", 64'(bus.lock_timeout), 64'(ep));
      if (ep) void'(pq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    p_valid = '0; p_wr = '0; p_lock = '0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_wdata[i] = '0; end
    bus.req_valid = '0; bus.req_wr = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    model_reset();

    // Reset with every requester already asking, then continuous round-robin reads.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(i), '0);
    cycle(1'b1);
    cycle(1'b1);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!p_valid[i]) set_req(i, 1'b0, 1'b0, AW'(i), '0);
      cycle(1'b0);
    end
    p_valid = '0;
    cycle(1'b0);

    // Basic write then read back.
    set_req(0, 1'b1, 1'b0, 3'd3, 32'hDEAD_BEEF);
    cycle(1'b0);
    set_req(0, 1'b0, 1'b0, 3'd3, '0);
    cycle(1'b0);
    cycle(1'b0);

    // Lock by requester 2 while 0 and 1 wait, unlocking write three cycles later.
    set_req(2, 1'b0, 1'b1, 3'd1, '0);
    cycle(1'b0);
    set_req(0, 1'b0, 1'b0, 3'd2, '0);
    set_req(1, 1'b0, 1'b0, 3'd4, '0);
    cycle(1'b0);
    cycle(1'b0);
    set_req(2, 1'b1, 1'b0, 3'd1, 32'h1234_5678);
    set_req(3, 1'b0, 1'b0, 3'd1, '0);
    for (int c = 0; c < 5; c++) cycle(1'b0);

    // Lock by requester 1 that then goes quiet: forced release.
    set_req(1, 1'b0, 1'b1, 3'd0, '0);
    cycle(1'b0);
    set_req(0, 1'b0, 1'b0, 3'd5, '0);
    for (int c = 0; c < 7; c++) cycle(1'b0);

    // Out-of-range write and read.
    set_req(0, 1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
    cycle(1'b0);
    set_req(3, 1'b0, 1'b0, 3'd6, '0);
    cycle(1'b0);

    // Read transfer followed by reset with another read pending.
    set_req(1, 1'b0, 1'b0, 3'd3, '0);
    cycle(1'b0);
    set_req(1, 1'b0, 1'b0, 3'd2, '0);
    cycle(1'b1);
    p_valid = '0;
    cycle(1'b0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                    AW'($urandom_range(0, 7)), DW'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          p_valid[i] = 1'b0;
        end
      end
      cycle(1'($urandom_range(0, 99) == 0));
    end

    p_valid = '0;
    for (int c = 0; c < 3; c++) cycle(1'b0);
    @(posedge clk);
    #2;
    chk("rsp_drain", 64'(rq.size()), 64'd0);
    chk("pulse_drain", 64'(pq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
